sccb_responder: RTL and testbench

SCCB (OV7670-style, I2C-like) target-side engine: it answers the other end of the bus that the team's SCCB master drives. It sits on the open-drain SIOC/SIOD pads, decodes START/STOP, ID, sub-address and data phases, and presents register writes and reads to a parallel register bank. It is used as a camera emulator for loop-back bring-up and as the target half of FPGA-to-FPGA SCCB links.

---
 rtl/sccb_pkg.sv | 27 ++
 rtl/sccb_line_sync.sv | 35 +++
 rtl/sccb_responder.sv | 166 ++++++++++++++++
 tb/tb_sccb_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_pkg
// Description : Shared SCCB types and constants for the master and responder.
// Revision    : 1.0
// ============================================================================
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_ADDR      = 4'd3,
        ST_ADDR_ACK  = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RD_NA     = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

    localparam logic       SCCB_WR_BIT     = 1'b0;
    localparam logic       SCCB_RD_BIT     = 1'b1;
    localparam logic [6:0] SCCB_DEFAULT_ID = 7'h21;

endpackage : sccb_pkg
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : sccb_line_sync
// Description : 2-FF synchronizer plus history flop with edge detect, one line.
// Revision    : 1.0
// ============================================================================
module sccb_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       hist_q;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            hist_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~hist_q;
    assign fall_o  = ~sync_q[1] & hist_q;

endmodule : sccb_line_sync
`default_nettype wire

// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
// Module      : sccb_responder
// Description : SCCB target engine bridging bus transfers to a register bank.
// Revision    : 1.0
// ============================================================================
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ID = SCCB_DEFAULT_ID
) (
    input  logic       clk_12MHz,
    input  logic       rst_n,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    sccb_state_e state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  tx_q;
    logic        oe_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic        busy_q;

    sccb_line_sync u_sioc_sync (
        .clk_i   (clk_12MHz),
        .rst_ni  (rst_n),
        .line_i  (sioc_in),
        .level_o (w_scl_lvl),
        .rise_o  (w_scl_rise),
        .fall_o  (w_scl_fall)
    );

    sccb_line_sync u_siod_sync (
        .clk_i   (clk_12MHz),
        .rst_ni  (rst_n),
        .line_i  (siod_in),
        .level_o (w_sda_lvl),
        .rise_o  (w_sda_rise),
        .fall_o  (w_sda_fall)
    );

    assign w_start = w_scl_lvl & w_sda_fall;
    assign w_stop  = w_scl_lvl & w_sda_rise;

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            tx_q    <= 8'h00;
            oe_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (w_start) begin
                state_q <= ST_ID;
                cnt_q   <= 4'd0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else if (w_stop) begin
                state_q <= ST_IDLE;
                cnt_q   <= 4'd0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (w_scl_rise) begin
                if ((state_q inside {ST_ID, ST_ADDR, ST_WDATA}) && (cnt_q != 4'd8)) begin
                    shift_q <= {shift_q[6:0], w_sda_lvl};
                    cnt_q   <= cnt_q + 4'd1;
                end
            end else if (w_scl_fall) begin
                case (state_q)
                    ST_ID: begin
                        if (cnt_q == 4'd8) begin
                            cnt_q <= 4'd0;
                            if (shift_q[7:1] == DEVICE_ID) begin
                                state_q <= ST_ID_ACK;
                                oe_q    <= 1'b1;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    // shift_q[0] still holds the R/W bit: no bits are shifted during ACK.
                    ST_ID_ACK: begin
                        if (shift_q[0] == SCCB_RD_BIT) begin
                            state_q <= ST_RDATA;
                            tx_q    <= reg_rdata;
                            oe_q    <= ~reg_rdata[7];
                            cnt_q   <= 4'd1;
                        end else begin
                            state_q <= ST_ADDR;
                            oe_q    <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        if (cnt_q == 4'd8) begin
                            addr_q  <= shift_q;
                            state_q <= ST_ADDR_ACK;
                            oe_q    <= 1'b1;
                            cnt_q   <= 4'd0;
                        end
                    end
                    ST_ADDR_ACK: begin
                        state_q <= ST_WDATA;
                        oe_q    <= 1'b0;
                    end
                    ST_WDATA: begin
                        if (cnt_q == 4'd8) begin
                            wdata_q <= shift_q;
                            we_q    <= 1'b1;
                            state_q <= ST_WDATA_ACK;
                            oe_q    <= 1'b1;
                            cnt_q   <= 4'd0;
                        end
                    end
                    ST_WDATA_ACK: begin
                        state_q <= ST_IGNORE;
                        oe_q    <= 1'b0;
                    end
                    // cnt_q counts bits already placed on the bus.
                    ST_RDATA: begin
                        if (cnt_q == 4'd8) begin
                            state_q <= ST_RD_NA;
                            oe_q    <= 1'b0;
                            cnt_q   <= 4'd0;
                        end else begin
                            tx_q  <= {tx_q[6:0], 1'b0};
                            oe_q  <= ~tx_q[6];
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    ST_RD_NA: begin
                        state_q <= ST_IGNORE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign siod_oe   = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign busy      = busy_q;

endmodule : sccb_responder
`default_nettype wire

// File: tb/tb_sccb_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sccb_responder
// Description : Randomized scoreboard bench driving an SCCB master model.
// Revision    : 1.0
// ============================================================================
module tb_sccb_responder;
    import sccb_pkg::*;

    logic       clk_12MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       siod_line;
    logic       siod_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    always #42 clk_12MHz = ~clk_12MHz;

    assign siod_line = m_sda & ~siod_oe;

    sccb_responder dut (
        .clk_12MHz (clk_12MHz),
        .rst_n     (rst_n),
        .sioc_in   (m_scl),
        .siod_in   (siod_line),
        .siod_oe   (siod_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    logic [7:0] bank [256];
    assign reg_rdata = bank[reg_addr];

    int checks   = 0;
    int failures = 0;
    int q        = 30;
    bit lat_chk  = 1'b0;
    bit watch_oe = 1'b0;
    bit oe_seen  = 1'b0;

    logic [7:0]  exp_q   [$];
    string       exp_tag [$];
    logic [7:0]  obs_q   [$];
    logic [15:0] exp_wr  [$];

    logic [7:0] model_mem [256];
    logic [7:0] model_ptr;
    logic [7:0] data_buf  [4];

    function automatic logic [7:0] init_val(input logic [7:0] a);
        logic [7:0] t;
        if (a == 8'h0A) return 8'h76;
        t = a * 8'd37;
        return t ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: register-bank side plus bus-sample scoreboard.
    initial begin
        logic [15:0] e;
        logic [7:0]  o;
        logic [7:0]  x;
        string       tg;
        for (int i = 0; i < 256; i++) bank[i] = init_val(i[7:0]);
        forever begin
            @(negedge clk_12MHz);
            if (watch_oe && siod_oe) oe_seen = 1'b1;
            if (rst_n && reg_we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_we", {reg_addr, reg_wdata}, 16'h0000);
                    if ({reg_addr, reg_wdata} == 16'h0000) begin
                        failures++;
                        $display("FAIL unexpected_we: got pulse expected none");
                    end
                end else begin
                    e = exp_wr.pop_front();
                    chk("we_addr_data", {reg_addr, reg_wdata}, e);
                end
                bank[reg_addr] = reg_wdata;
            end
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    chk("unexpected_bus_sample", {8'h00, o}, 16'hFFFF);
                end else begin
                    x  = exp_q.pop_front();
                    tg = exp_tag.pop_front();
                    chk(tg, {8'h00, o}, {8'h00, x});
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk_12MHz);
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic wq();
        repeat (q) @(negedge clk_12MHz);
    endtask

    task automatic expect_bus(input string tag, input logic [7:0] v);
        exp_q.push_back(v);
        exp_tag.push_back(tag);
    endtask

    task automatic m_start();
        if (!m_scl) begin
            m_sda = 1'b1; wq();
            m_scl = 1'b1; wq();
        end
        m_sda = 1'b0;
        if (lat_chk) begin
            repeat (2) @(negedge clk_12MHz);
            chk("busy_before_3cyc", {15'd0, busy}, 16'd0);
            @(negedge clk_12MHz);
            chk("busy_at_3cyc", {15'd0, busy}, 16'd1);
            repeat (q - 3) @(negedge clk_12MHz);
        end else begin
            wq();
        end
        m_scl = 1'b0; wq();
    endtask

    task automatic m_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
        wq();
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda = b; wq();
        m_scl = 1'b1; wq();
        s = siod_line; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic m_send(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        obs_q.push_back({7'd0, s});
    endtask

    task automatic m_recv();
        logic [7:0] d;
        logic       s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, s);
            d = {d[6:0], s};
        end
        obs_q.push_back(d);
        m_bit(1'b1, s);
        obs_q.push_back({7'd0, s});
    endtask

    // Reference behaviour: ACK (line low) only for a matching ID, the address
    // of a matching write, and the first data byte; only that byte is written.
    task automatic xfer_write(input logic [7:0] id, input logic [7:0] addr,
                              input int nd, input bit do_stop);
        bit id_ok;
        bit wr_ok;
        id_ok = (id[7:1] == SCCB_DEFAULT_ID);
        wr_ok = id_ok && (id[0] == SCCB_WR_BIT);
        m_start();
        expect_bus("ack_id", id_ok ? 8'h00 : 8'h01);
        m_send(id);
        expect_bus("ack_addr", wr_ok ? 8'h00 : 8'h01);
        m_send(addr);
        if (wr_ok) model_ptr = addr;
        for (int i = 0; i < nd; i++) begin
            expect_bus("ack_data", (wr_ok && i == 0) ? 8'h00 : 8'h01);
            if (wr_ok && i == 0) begin
                exp_wr.push_back({addr, data_buf[0]});
                model_mem[addr] = data_buf[0];
            end
            m_send(data_buf[i]);
        end
        if (do_stop) m_stop();
    endtask

    task automatic xfer_read(input logic [7:0] id, input bit do_stop);
        bit id_ok;
        id_ok = (id[7:1] == SCCB_DEFAULT_ID);
        m_start();
        expect_bus("ack_rid", id_ok ? 8'h00 : 8'h01);
        m_send(id);
        expect_bus("rdata", id_ok ? model_mem[model_ptr] : 8'hFF);
        expect_bus("rd_release", 8'h01);
        m_recv();
        if (do_stop) m_stop();
    endtask

    initial begin
        logic       s;
        logic [7:0] id;
        int         k;
        int         kind;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i[7:0]);
        model_ptr = 8'h00;

        #100;
        chk("rst_siod_oe",   {15'd0, siod_oe}, 16'd0);
        chk("rst_reg_we",    {15'd0, reg_we},  16'd0);
        chk("rst_busy",      {15'd0, busy},    16'd0);
        chk("rst_reg_addr",  {8'd0, reg_addr},  16'h0000);
        chk("rst_reg_wdata", {8'd0, reg_wdata}, 16'h0000);
        repeat (3) @(negedge clk_12MHz);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_12MHz);

        // 3-phase write at ~100 kHz
        q = 30;
        lat_chk = 1'b1;
        data_buf[0] = 8'h80;
        xfer_write(8'h42, 8'h12, 1, 1'b1);
        lat_chk = 1'b0;
        chk("t1_addr",  {8'd0, reg_addr},  16'h0012);
        chk("t1_wdata", {8'd0, reg_wdata}, 16'h0080);
        chk("t1_busy_after_stop", {15'd0, busy}, 16'd0);

        // 2-phase write then 2-phase read
        xfer_write(8'h42, 8'h0A, 0, 1'b1);
        xfer_read(8'h43, 1'b1);
        chk("t2_addr", {8'd0, reg_addr}, 16'h000A);

        // Wrong ID: no drive on SIOD at all
        data_buf[0] = 8'h11; data_buf[1] = 8'h22;
        oe_seen = 1'b0; watch_oe = 1'b1;
        xfer_write(8'h60, 8'h33, 2, 1'b1);
        watch_oe = 1'b0;
        chk("t3_no_oe", {15'd0, oe_seen}, 16'd0);
        chk("t3_addr_kept", {8'd0, reg_addr}, 16'h000A);

        // Repeated START after 4 bits of WDATA
        xfer_write(8'h42, 8'h20, 0, 1'b0);
        for (int i = 0; i < 4; i++) m_bit(i[0], s);
        data_buf[0] = 8'h55;
        xfer_write(8'h42, 8'h3A, 1, 1'b1);
        chk("t4_addr", {8'd0, reg_addr}, 16'h003A);

        // Four data bytes after one address
        for (int i = 0; i < 4; i++) data_buf[i] = 8'($urandom);
        xfer_write(8'h42, 8'($urandom), 4, 1'b1);

        // Reset asserted while ACK is being driven
        id = 8'h42;
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(id[i], s);
        m_sda = 1'b1;
        k = 0;
        while (!siod_oe && k < 20) begin
            @(negedge clk_12MHz);
            k++;
        end
        chk("t6_ack_driven", {15'd0, siod_oe}, 16'd1);
        #5 rst_n = 1'b0;
        #1;
        chk("t6_rst_oe",   {15'd0, siod_oe}, 16'd0);
        chk("t6_rst_busy", {15'd0, busy},    16'd0);
        chk("t6_rst_addr", {8'd0, reg_addr},  16'h0000);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (10) @(negedge clk_12MHz);
        rst_n = 1'b1;
        model_ptr = 8'h00;
        repeat (5) @(negedge clk_12MHz);
        data_buf[0] = 8'($urandom);
        xfer_write(8'h42, 8'h5C, 1, 1'b1);
        chk("t6_addr_after", {8'd0, reg_addr}, 16'h005C);

        // Randomized mix of transactions at a faster bit rate
        q = 8;
        for (int n = 0; n < 12; n++) begin
            kind = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) data_buf[i] = 8'($urandom);
            case (kind)
                0: xfer_write(8'h42, 8'($urandom), $urandom_range(1, 3), (n == 11) || ($urandom_range(0, 1) == 1));
                1: xfer_write(8'h42, 8'($urandom), 0, (n == 11) || ($urandom_range(0, 1) == 1));
                2: xfer_read(8'h43, (n == 11) || ($urandom_range(0, 1) == 1));
                default: begin
                    id = 8'($urandom);
                    if (id[7:1] == SCCB_DEFAULT_ID) id[7] = ~id[7];
                    xfer_write(id, 8'($urandom), $urandom_range(0, 2), (n == 11) || ($urandom_range(0, 1) == 1));
                end
            endcase
        end

        repeat (50) @(negedge clk_12MHz);
        chk("final_addr", {8'd0, reg_addr}, {8'd0, model_ptr});
        chk("final_busy", {15'd0, busy}, 16'd0);
        chk("pending_writes", 16'(exp_wr.size()), 16'd0);
        chk("pending_bus", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sccb_responder
`default_nettype wire
